// File: rtl/czcore_pkg.sv
// Shared core definitions: fetch defaults, instruction width and the
// fetch packet that carries an instruction word together with its PC.
package czcore_pkg;

  localparam int unsigned PC_WIDTH_DEF = 10;
  localparam int unsigned RESET_PC_DEF = 0;
  localparam int unsigned IR_WIDTH     = 32;

  typedef struct packed {
    logic [IR_WIDTH-1:0]     ir;
    logic [PC_WIDTH_DEF-1:0] pc;
  } fetch_pkt_t;

endpackage

// File: rtl/czfetch_q.sv
// Two-entry synchronous FIFO for fetched packets. The head is always entry 0,
// so the offered packet comes straight from a register.
module czfetch_q
  import czcore_pkg::*;
#(
  parameter type pkt_t = fetch_pkt_t
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  pkt_t       din,
  output pkt_t       head,
  output logic [1:0] occ
);

  pkt_t e0;
  pkt_t e1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ <= '0;
    end else if (flush) begin
      occ <= '0;
    end else if (push && pop) begin
      // Simultaneous push/pop: shift when full, otherwise the new word becomes head.
      if (occ == 2'd2) begin
        e0 <= e1;
        e1 <= din;
      end else begin
        e0 <= din;
      end
    end else if (push) begin
      if (occ == 2'd0) e0 <= din;
      else             e1 <= din;
      occ <= occ + 2'd1;
    end else if (pop) begin
      e0  <= e1;
      occ <= occ - 2'd1;
    end
  end

  assign head = e0;

endmodule

// File: rtl/czfetch.sv
// Instruction fetch stage: drives the program ROM address, captures its
// 1-cycle-latency data and hands PC-tagged words to decode over valid/ready.
module czfetch
  import czcore_pkg::*;
#(
  parameter int unsigned PC_WIDTH = PC_WIDTH_DEF,
  parameter int unsigned RESET_PC = RESET_PC_DEF
) (
  input  logic                CLK,
  input  logic                RSTn,
  output logic [PC_WIDTH-1:0] xPC_P,
  input  logic [IR_WIDTH-1:0] xIR_P,
  input  logic                redir_valid,
  input  logic [PC_WIDTH-1:0] redir_pc,
  output logic                if_valid,
  input  logic                if_ready,
  output logic [IR_WIDTH-1:0] if_ir,
  output logic [PC_WIDTH-1:0] if_pc
);

  typedef struct packed {
    logic [IR_WIDTH-1:0] ir;
    logic [PC_WIDTH-1:0] pc;
  } pkt_t;

  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] inf_pc;
  logic                inf_v;
  logic [1:0]          occ;
  logic [2:0]          credit;
  logic                pop;
  logic                push;
  logic                issue;
  pkt_t                din;
  pkt_t                head;

  assign xPC_P = redir_valid ? redir_pc : pc_q;

  assign pop = if_valid & if_ready;

  // Slots committed after this cycle; issuing only below 2 keeps a push from overflowing.
  assign credit = {1'b0, occ} + {2'b00, inf_v} - {2'b00, pop};
  assign issue  = RSTn & (redir_valid | (credit < 3'd2));
  assign push   = inf_v & ~redir_valid;

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      pc_q  <= PC_WIDTH'(RESET_PC);
      inf_v <= 1'b0;
    end else if (issue) begin
      inf_v  <= 1'b1;
      inf_pc <= xPC_P;
      pc_q   <= xPC_P + PC_WIDTH'(1);
    end else begin
      inf_v <= 1'b0;
    end
  end

  always_comb begin
    din    = '0;
    din.ir = xIR_P;
    din.pc = inf_pc;
  end

  czfetch_q #(
    .pkt_t(pkt_t)
  ) u_q (
    .clk  (CLK),
    .rst_n(RSTn),
    .push (push),
    .pop  (pop),
    .flush(redir_valid),
    .din  (din),
    .head (head),
    .occ  (occ)
  );

  assign if_valid = (occ != 2'd0);
  assign if_ir    = head.ir;
  assign if_pc    = head.pc;

endmodule

// File: tb/tb_czfetch.sv
// Directed bench for czfetch with a 1-cycle-latency ROM model (word i = A000_0000 + i).
module tb_czfetch;

  logic        clk;
  logic        RSTn;
  logic [9:0]  xPC_P;
  logic [31:0] xIR_P;
  logic        redir_valid;
  logic [9:0]  redir_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_ir;
  logic [9:0]  if_pc;

  int n_checks = 0;
  int n_fail   = 0;

  czfetch #(
    .PC_WIDTH(10),
    .RESET_PC(0)
  ) dut (
    .CLK        (clk),
    .RSTn       (RSTn),
    .xPC_P      (xPC_P),
    .xIR_P      (xIR_P),
    .redir_valid(redir_valid),
    .redir_pc   (redir_pc),
    .if_valid   (if_valid),
    .if_ready   (if_ready),
    .if_ir      (if_ir),
    .if_pc      (if_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) xIR_P <= 32'hA000_0000 + {22'b0, xPC_P};

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Leaves the bench in cycle 0, the first cycle with RSTn high.
  task automatic reset_dut();
    RSTn        = 1'b0;
    redir_valid = 1'b0;
    redir_pc    = '0;
    if_ready    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    RSTn = 1'b1;
    #1;
  endtask

  task automatic go(input logic rdy, input logic rv, input logic [9:0] rpc);
    @(posedge clk);
    #1;
    if_ready    = rdy;
    redir_valid = rv;
    redir_pc    = rpc;
    #1;
  endtask

  task automatic check_offer(input string tag, input logic [9:0] pc);
    check_eq({tag, "_valid"}, 64'(if_valid), 64'd1);
    check_eq({tag, "_pc"},    64'(if_pc),    64'(pc));
    check_eq({tag, "_ir"},    64'(if_ir),    64'(32'hA000_0000 + {22'b0, pc}));
  endtask

  initial begin
    // Straight run after reset
    reset_dut();
    check_eq("rst_valid", 64'(if_valid), 64'd0);
    check_eq("rst_xpc",   64'(xPC_P),    64'd0);
    go(1'b1, 1'b0, '0);
    check_eq("c1_valid", 64'(if_valid), 64'd0);
    for (int i = 0; i < 4; i++) begin
      go(1'b1, 1'b0, '0);
      check_offer("seq", 10'(i));
    end

    // Back-pressure: queue fills, issue stops, head holds
    reset_dut();
    go(1'b1, 1'b0, '0);
    go(1'b0, 1'b0, '0);
    check_offer("bp_c2", 10'd0);
    for (int i = 0; i < 4; i++) begin
      go(1'b0, 1'b0, '0);
      check_eq("bp_occ", 64'(dut.u_q.occ), 64'd2);
      check_eq("bp_xpc", 64'(xPC_P),       64'd2);
      check_offer("bp_hold", 10'd0);
    end
    for (int i = 0; i < 4; i++) begin
      go(1'b1, 1'b0, '0);
      check_offer("bp_rel", 10'(i));
    end

    // Redirect while full
    reset_dut();
    go(1'b1, 1'b0, '0);
    for (int i = 0; i < 4; i++) go(1'b0, 1'b0, '0);
    go(1'b0, 1'b1, 10'h200);
    check_eq("rd_xpc", 64'(xPC_P), 64'h200);
    go(1'b1, 1'b0, '0);
    check_eq("rd_c7_valid", 64'(if_valid), 64'd0);
    go(1'b1, 1'b0, '0);
    check_offer("rd_c8", 10'h200);
    go(1'b1, 1'b0, '0);
    check_offer("rd_c9", 10'h201);

    // Back-to-back redirects: last wins
    reset_dut();
    for (int i = 0; i < 5; i++) go(1'b1, 1'b0, '0);
    go(1'b1, 1'b1, 10'h100);
    go(1'b1, 1'b1, 10'h300);
    check_eq("bb_c7_valid", 64'(if_valid), 64'd0);
    go(1'b1, 1'b0, '0);
    check_eq("bb_c8_valid", 64'(if_valid), 64'd0);
    go(1'b1, 1'b0, '0);
    check_offer("bb_c9", 10'h300);
    go(1'b1, 1'b0, '0);
    check_offer("bb_c10", 10'h301);

    // PC wrap
    reset_dut();
    go(1'b1, 1'b0, '0);
    go(1'b1, 1'b1, 10'h3FE);
    go(1'b1, 1'b0, '0);
    check_eq("wr_c3_valid", 64'(if_valid), 64'd0);
    go(1'b1, 1'b0, '0);
    check_offer("wr_3fe", 10'h3FE);
    go(1'b1, 1'b0, '0);
    check_offer("wr_3ff", 10'h3FF);
    go(1'b1, 1'b0, '0);
    check_offer("wr_000", 10'h000);
    go(1'b1, 1'b0, '0);
    check_offer("wr_001", 10'h001);

    // Mid-stream reset with full queue; redirect during reset is ignored
    reset_dut();
    go(1'b1, 1'b0, '0);
    for (int i = 0; i < 4; i++) go(1'b0, 1'b0, '0);
    @(posedge clk);
    #1;
    RSTn        = 1'b0;
    redir_valid = 1'b1;
    redir_pc    = 10'h155;
    if_ready    = 1'b0;
    #1;
    check_eq("mr_xpc_comb", 64'(xPC_P), 64'h155);
    @(posedge clk);
    #1;
    RSTn        = 1'b1;
    redir_valid = 1'b0;
    redir_pc    = '0;
    if_ready    = 1'b1;
    #1;
    check_eq("mr_c0_valid", 64'(if_valid), 64'd0);
    check_eq("mr_c0_xpc",   64'(xPC_P),    64'd0);
    go(1'b1, 1'b0, '0);
    check_eq("mr_c1_valid", 64'(if_valid), 64'd0);
    go(1'b1, 1'b0, '0);
    check_offer("mr_c2", 10'd0);
    go(1'b1, 1'b0, '0);
    check_offer("mr_c3", 10'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
